tcb_dec: RTL

Parametrised TCB address decoder. It routes one manager's requests to PN subordinate ports using wildcard address patterns, and returns each response from the port that accepted the matching request exactly DLY cycles earlier. It supports back-to-back transfers with DLY>1 through a response-select delay line. Unmapped addresses are answered locally with an error. It replaces fixed-port decoders between the CPU bus and the SoC peripheral/memory fabric.

---
 rtl/tcb_pkg.sv | 25 ++
 rtl/tcb_if.sv | 37 +++
 rtl/tcb_dec_dly.sv | 43 ++++
 rtl/tcb_dec.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/tcb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tcb_pkg
// Description : Types and limits shared by the TCB decoder and its delay line.
//               tcb_dec_ent_t is one response-select record: whether a
//               transfer happened, which port took it and (when local error
//               responses are built in) whether it was unmapped.
// Config      : TCB_DEC_ERR_EN adds the miss field to tcb_dec_ent_t.
// Revision    : 1.0 - initial release
// ============================================================================
package tcb_pkg;

    localparam int unsigned TCB_DEC_PN_MAX = 16;
    localparam int unsigned TCB_DLY_MAX    = 8;

    typedef struct packed {
        logic       act;
        logic [3:0] sel;
`ifdef TCB_DEC_ERR_EN
        logic       miss;
`endif
    } tcb_dec_ent_t;

endpackage
`default_nettype wire

// File: rtl/tcb_if.sv
`default_nettype none
// ============================================================================
// Module      : tcb_if
// Description : TCB bus bundle. The manager drives the request (vld, wen,
//               ben, adr, wdt); the subordinate drives rdy in the request
//               cycle and rdt/err exactly DLY cycles after acceptance.
// Ports       : clk - bus clock, rst - asynchronous active-low reset
// Revision    : 1.0 - initial release
// ============================================================================
interface tcb_if #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned DLY = 1
)(
    input logic clk,
    input logic rst
);
    localparam int unsigned BW = DW / 8;

    logic          vld;
    logic          wen;
    logic [BW-1:0] ben;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdt;
    logic          rdy;
    logic [DW-1:0] rdt;
    logic          err;

    // clk/rst are carried for attached devices; the bundle itself never uses them
    logic w_unused;
    assign w_unused = clk ^ rst;

    modport man (input clk, rst, output vld, wen, ben, adr, wdt, input  rdy, rdt, err);
    modport sub (input clk, rst, input  vld, wen, ben, adr, wdt, output rdy, rdt, err);

endinterface
`default_nettype wire

// File: rtl/tcb_dec_dly.sv
`default_nettype none
// ============================================================================
// Module      : tcb_dec_dly
// Description : DLY-stage shift register of response-select records. Shifts
//               every clock with no stall; DLY=0 degenerates to a wire.
// Ports       : clk  - clock
//               rst  - asynchronous active-low reset (clears every stage)
//               din  - record for the current cycle
//               dout - record from DLY cycles ago
// Revision    : 1.0 - initial release
// ============================================================================
module tcb_dec_dly
    import tcb_pkg::*;
#(
    parameter int unsigned DLY = 1
)(
    input  logic         clk,
    input  logic         rst,
    input  tcb_dec_ent_t din,
    output tcb_dec_ent_t dout
);

    if (DLY == 0) begin : g_wire
        logic w_unused;
        assign w_unused = clk ^ rst;
        assign dout     = din;
    end else begin : g_pipe
        tcb_dec_ent_t r_ent [DLY];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k < DLY; k++) r_ent[k] <= '0;
            end else begin
                r_ent[0] <= din;
                for (int k = 1; k < DLY; k++) r_ent[k] <= r_ent[k-1];
            end
        end

        assign dout = r_ent[DLY-1];
    end

endmodule
`default_nettype wire

// File: rtl/tcb_dec.sv
`default_nettype none
// ============================================================================
// Module      : tcb_dec
// Description : TCB address decoder. Routes one manager to PN subordinate
//               ports by wildcard address pattern (lowest index wins) and
//               returns each response from the port that accepted the request
//               DLY cycles earlier.
// Ports       : clk - clock shared by all attached buses
//               rst - asynchronous active-low reset
//               sub - subordinate side (the manager device connects here)
//               man - PN manager sides (subordinate devices connect here)
// Config      : TCB_DEC_ERR_EN - unmapped addresses are accepted locally and
//               answered with err=1; undefined, they go to port PN-1.
// Revision    : 1.0 - initial release
// ============================================================================
module tcb_dec
    import tcb_pkg::*;
#(
    parameter int unsigned           AW  = 32,
    parameter int unsigned           DW  = 32,
    parameter int unsigned           DLY = 1,
    parameter int unsigned           PN  = 4,
    parameter logic [PN-1:0][AW-1:0] AS  = {PN{{AW{1'bx}}}}
)(
    input  logic clk,
    input  logic rst,
    tcb_if.sub   sub,
    tcb_if.man   man [PN-1:0]
);

    localparam int unsigned SW = (PN > 1) ? $clog2(PN) : 1;

    // elaboration checks
    if (PN > TCB_DEC_PN_MAX) begin : g_err_pn
        $error("tcb_dec: PN=%0d exceeds %0d", PN, TCB_DEC_PN_MAX);
    end
    if (DLY > TCB_DLY_MAX) begin : g_err_dly
        $error("tcb_dec: DLY=%0d exceeds %0d", DLY, TCB_DLY_MAX);
    end
    if (($bits(sub.wdt) != DW) || ($bits(sub.ben) != DW/8) || (sub.DLY != DLY)) begin : g_err_sub
        $error("tcb_dec: sub interface DW/BW/DLY mismatch");
    end

    logic [PN-1:0]   w_hit;
    logic [PN-1:0]   w_fwd;
    logic [PN-1:0]   w_man_rdy;
    logic [PN-1:0]   w_man_err;
    logic [DW-1:0]   w_man_rdt [PN];
    logic [SW-1:0]   w_dec_sel;
    logic [SW-1:0]   w_sel;
    logic            w_miss;
    logic            w_sel_rdy;
    logic            w_rdy;
    tcb_dec_ent_t    w_ent;
    tcb_dec_ent_t    w_ent_d;
    logic [DW-1:0]   w_rdt_d;
    logic            w_err_d;

    for (genvar i = 0; i < PN; i++) begin : g_port
        if (($bits(man[i].wdt) != DW) || ($bits(man[i].ben) != DW/8) || (man[i].DLY != DLY)) begin : g_err_man
            $error("tcb_dec: man[%0d] interface DW/BW/DLY mismatch", i);
        end

        assign w_hit[i]     = (sub.adr ==? AS[i]);
        assign w_fwd[i]     = ~w_miss & (w_sel == SW'(i));
        assign w_man_rdy[i] = man[i].rdy;
        assign w_man_err[i] = man[i].err;
        assign w_man_rdt[i] = man[i].rdt;

        assign man[i].vld   = sub.vld & w_fwd[i];
`ifdef SYNTHESIS
        assign man[i].wen   = sub.wen;
        assign man[i].ben   = sub.ben;
        assign man[i].adr   = sub.adr;
        assign man[i].wdt   = sub.wdt;
`else
        // non-selected ports see 'x so stray use of their request shows up
        assign man[i].wen   = w_fwd[i] ? sub.wen : 'x;
        assign man[i].ben   = w_fwd[i] ? sub.ben : 'x;
        assign man[i].adr   = w_fwd[i] ? sub.adr : 'x;
        assign man[i].wdt   = w_fwd[i] ? sub.wdt : 'x;
`endif
    end

    // priority encoder: scanning downward leaves the lowest hit index
    always_comb begin
        w_dec_sel = '0;
        for (int i = PN-1; i >= 0; i--) begin
            if (w_hit[i]) w_dec_sel = SW'(i);
        end
    end

`ifdef TCB_DEC_ERR_EN
    assign w_miss = ~|w_hit;
    assign w_sel  = w_dec_sel;
`else
    assign w_miss = 1'b0;
    assign w_sel  = (|w_hit) ? w_dec_sel : SW'(PN-1);
`endif

    always_comb begin
        w_sel_rdy = 1'b0;
        for (int i = 0; i < PN; i++) begin
            if (w_sel == SW'(i)) w_sel_rdy = w_man_rdy[i];
        end
    end

    // the local error responder always accepts
    assign w_rdy   = w_miss | w_sel_rdy;
    assign sub.rdy = w_rdy;

    always_comb begin
        w_ent     = '0;
        w_ent.act = sub.vld & w_rdy;
        w_ent.sel = 4'(w_sel);
`ifdef TCB_DEC_ERR_EN
        w_ent.miss = w_miss;
`endif
    end

    tcb_dec_dly #(
        .DLY  (DLY)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (w_ent),
        .dout (w_ent_d)
    );

    always_comb begin
        w_rdt_d = '0;
        w_err_d = 1'b0;
        for (int i = 0; i < PN; i++) begin
            if (w_ent_d.sel == 4'(i)) begin
                w_rdt_d = w_man_rdt[i];
                w_err_d = w_man_err[i];
            end
        end
    end

`ifdef TCB_DEC_ERR_EN
    assign sub.err = w_ent_d.act & (w_ent_d.miss | w_err_d);
    assign sub.rdt = (w_ent_d.act & w_ent_d.miss) ? '0 : w_rdt_d;
`else
    assign sub.err = w_ent_d.act & w_err_d;
    assign sub.rdt = w_rdt_d;
`endif

endmodule
`default_nettype wire
